// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, data width and parity-type constants.
package uart_pkg;

   localparam int   UART_DATA_W = 8;
   localparam logic PAR_EVEN    = 1'b0;
   localparam logic PAR_ODD     = 1'b1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first valid index after ptr_i, wrapping explicitly.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   always_comb begin
      int   c;
      logic found;
      c     = 0;
      found = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = (int'(ptr_i) + k) % NUM_REQ;
         if (!found && valid_i[c]) begin
            found    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter with per-frame parity latching and start timeout.
// Define UART_TX_ARB_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = UART_DATA_W,
   parameter int START_TO = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        cfg_par_en,
   input  logic                        cfg_par_typ,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        tx_valid,
   output logic                        tx_par_en,
   output logic                        tx_par_typ,
   input  logic                        tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        arb_busy,
`ifdef UART_TX_ARB_STATS_EN
   output logic [15:0]                 frame_cnt,
   output logic [7:0]                  err_cnt,
`endif
   output logic                        start_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(START_TO + 1);

   arb_state_e          state_q;
   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       gid_q;
   logic [CW-1:0]       cnt_q;
   logic [DATA_W-1:0]   data_q;
   logic                par_en_q;
   logic                par_typ_q;
   logic                valid_q;
   logic                err_q;

   logic [NUM_REQ-1:0]  win_gnt;
   logic [IW-1:0]       win_idx;
   logic                win_any;
   logic                accept;
   logic                enter_done;
   logic                to_fire;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (win_gnt),
      .idx_o   (win_idx),
      .any_o   (win_any)
   );

   // RST gates the strobe so req_ready is 0 during reset even though IDLE looks open.
   assign accept     = (state_q == IDLE) && !tx_busy && win_any && !RST;
   assign enter_done = (state_q == WAIT_START) && tx_busy;
   assign to_fire    = (state_q == WAIT_START) && !tx_busy && (cnt_q == CW'(START_TO - 1));

   assign req_ready  = accept ? win_gnt : '0;
   assign tx_data    = data_q;
   assign tx_valid   = valid_q;
   assign tx_par_en  = par_en_q;
   assign tx_par_typ = par_typ_q;
   assign grant_id   = gid_q;
   assign arb_busy   = (state_q != IDLE);
   assign start_err  = err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(NUM_REQ - 1);
         gid_q     <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  data_q    <= req_data[int'(win_idx)*DATA_W +: DATA_W];
                  par_en_q  <= cfg_par_en;
                  par_typ_q <= cfg_par_typ;
                  gid_q     <= win_idx;
                  ptr_q     <= win_idx;
                  valid_q   <= 1'b1;
                  state_q   <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt_q   <= '0;
               state_q <= WAIT_START;
            end
            WAIT_START: begin
               if (enter_done) begin
                  state_q <= WAIT_DONE;
               end else if (to_fire) begin
                  // Byte is dropped on timeout; the requester was already acknowledged.
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_ARB_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  err_cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (enter_done) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (to_fire && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp/event model checked every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ  = 2;
   localparam int DATA_W   = 8;
   localparam int START_TO = 4;

   logic                      CLK;
   logic                      RST;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      cfg_par_en;
   logic                      cfg_par_typ;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_valid;
   logic                      tx_par_en;
   logic                      tx_par_typ;
   logic                      tx_busy = 1'b0;
   logic [0:0]                grant_id;
   logic                      arb_busy;
   logic                      start_err;
`ifdef UART_TX_ARB_STATS_EN
   logic [15:0]               frame_cnt;
   logic [7:0]                err_cnt;
`endif

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_TO(START_TO)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .cfg_par_en  (cfg_par_en),
      .cfg_par_typ (cfg_par_typ),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_par_en   (tx_par_en),
      .tx_par_typ  (tx_par_typ),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
`ifdef UART_TX_ARB_STATS_EN
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt),
`endif
      .start_err   (start_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, e, $time);
      end
   endtask

   // Transmitter model: BUSY rises tx_dly cycles after the launch pulse and lasts tx_len cycles.
   int tx_dly    = 2;
   int tx_len    = 5;
   bit tx_silent = 1'b0;
   int tx_t      = -1;
   always begin
      @(posedge CLK);
      #1;
      if (RST) begin
         tx_t    = -1;
         tx_busy = 1'b0;
      end else begin
         if (tx_valid && !tx_silent) tx_t = 0;
         else if (tx_t >= 0) tx_t++;
         tx_busy = (tx_t >= tx_dly) && (tx_t < tx_dly + tx_len);
         if (tx_t >= tx_dly + tx_len) tx_t = -1;
      end
   end

   function automatic int pick(input int last, input logic [NUM_REQ-1:0] v);
      for (int i = last + 1; i < NUM_REQ; i++) if (v[i]) return i;
      for (int i = 0; i <= last; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: the arbiter is either free or owns a frame whose milestones are timestamps.
   int          cyc = 0;
   bit          m_free;
   int          m_last, m_gid, m_launch, m_ws, m_err_at;
   bit          m_seen;
   logic [7:0]  m_data;
   logic        m_pe, m_pt;
   logic [15:0] m_frames;
   logic [7:0]  m_errs;
   int          gq[$];
   logic [7:0]  dq[$];

   always @(negedge CLK) begin
      logic [NUM_REQ-1:0] e_rdy;
      int w;
      e_rdy = '0;
      w     = -1;
      if (RST) begin
         m_free = 1'b1; m_last = NUM_REQ - 1; m_gid = 0; m_data = '0; m_pe = 1'b0; m_pt = 1'b0;
         m_launch = -1; m_ws = -1; m_err_at = -1; m_seen = 1'b0; m_frames = '0; m_errs = '0;
         chk("rst_outputs", {req_ready, tx_valid, tx_par_en, tx_par_typ, arb_busy, start_err, grant_id, tx_data}, 0);
      end else begin
         if (m_free && !tx_busy) begin
            w = pick(m_last, req_valid);
            if (w >= 0) e_rdy[w] = 1'b1;
         end
         chk("req_ready", req_ready, e_rdy);
         chk("tx_valid", tx_valid, cyc == m_launch);
         chk("start_err", start_err, cyc == m_err_at);
         chk("arb_busy", arb_busy, !m_free);
         chk("tx_data", tx_data, m_data);
         chk("tx_par_en", tx_par_en, m_pe);
         chk("tx_par_typ", tx_par_typ, m_pt);
         chk("grant_id", grant_id, m_gid);
`ifdef UART_TX_ARB_STATS_EN
         chk("frame_cnt", frame_cnt, m_frames);
         chk("err_cnt", err_cnt, m_errs);
`endif
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gq.push_back(i);
         if (tx_valid) dq.push_back(tx_data);
         if (w >= 0) begin
            m_last = w; m_gid = w; m_data = req_data[w*DATA_W +: DATA_W];
            m_pe = cfg_par_en; m_pt = cfg_par_typ; m_free = 1'b0;
            m_launch = cyc + 1; m_ws = cyc + 2; m_seen = 1'b0;
         end else if (!m_free && cyc >= m_ws) begin
            if (!m_seen) begin
               if (tx_busy) begin
                  m_seen = 1'b1;
                  m_frames = m_frames + 16'd1;
               end else if (cyc - m_ws + 1 == START_TO) begin
                  m_err_at = cyc + 1;
                  m_free   = 1'b1;
                  if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
               end
            end else if (!tx_busy) begin
               m_free = 1'b1;
            end
         end
      end
      cyc++;
   end

   task automatic send(input int i, input logic [7:0] d, input logic pe, input logic pt);
      bit ok;
      ok = 1'b0;
      @(posedge CLK); #1;
      req_valid[i] = 1'b1;
      req_data[i*DATA_W +: DATA_W] = d;
      cfg_par_en = pe;
      cfg_par_typ = pt;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (req_ready[i]) begin ok = 1'b1; break; end
      end
      chk("ready_wait", ok, 1);
      @(posedge CLK); #1;
      req_valid[i] = 1'b0;
      @(negedge CLK);
      chk("launch_valid", tx_valid, 1);
      chk("launch_data", tx_data, d);
      chk("launch_par_en", tx_par_en, pe);
      chk("launch_par_typ", tx_par_typ, pt);
      chk("launch_grant", grant_id, i);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (!arb_busy) begin ok = 1'b1; break; end
      end
      chk("idle_wait", ok, 1);
   endtask

   initial begin
      int errk;
      RST = 1'b1; req_valid = '0; req_data = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_tx_data", tx_data, 0);
      chk("reset_arb_busy", arb_busy, 0);
      @(posedge CLK); #1; RST = 1'b0;

      // Contention: both requesters valid continuously.
      tx_dly = 2; tx_len = 3;
      @(posedge CLK); #1;
      gq.delete(); dq.delete();
      req_data = 16'h2211; req_valid = 2'b11;
      for (int k = 0; k < 400 && gq.size() < 4; k++) @(negedge CLK);
      @(posedge CLK); #1; req_valid = 2'b00;
      wait_idle();
      chk("contention_count", gq.size() >= 4 && dq.size() >= 4, 1);
      if (gq.size() >= 4 && dq.size() >= 4) begin
         chk("grant0", gq[0], 0); chk("grant1", gq[1], 1);
         chk("grant2", gq[2], 0); chk("grant3", gq[3], 1);
         chk("data0", dq[0], 8'h11); chk("data1", dq[1], 8'h22);
         chk("data2", dq[2], 8'h11); chk("data3", dq[3], 8'h22);
      end

      // Single byte, then a lone requester granted twice despite the pointer.
      tx_dly = 2; tx_len = 5;
      send(0, 8'hA5, 1'b1, 1'b1);
      wait_idle();
      send(1, 8'h5C, 1'b0, 1'b0);
      wait_idle();
      send(1, 8'h6D, 1'b1, 1'b0);
      wait_idle();

      // Config change while the frame is in flight.
      tx_dly = 1; tx_len = 8;
      send(0, 8'h3C, 1'b1, 1'b0);
      repeat (3) @(negedge CLK);
      #2; cfg_par_typ = 1'b1; cfg_par_en = 1'b0;
      repeat (2) @(negedge CLK);
      chk("midframe_par_typ", tx_par_typ, 0);
      chk("midframe_par_en", tx_par_en, 1);
      wait_idle();
      send(1, 8'hC3, 1'b0, 1'b1);
      wait_idle();

      // Start timeout: BUSY never rises.
      tx_silent = 1'b1;
      send(0, 8'h5A, 1'b0, 1'b0);
      errk = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (start_err) begin errk = k; break; end
      end
      chk("timeout_cycles", errk, START_TO);
      chk("timeout_idle", arb_busy, 0);
      tx_silent = 1'b0; tx_dly = 2; tx_len = 3;
      send(1, 8'h77, 1'b1, 1'b1);
      wait_idle();

      // Reset in WAIT_DONE with both requesters pending.
      tx_dly = 1; tx_len = 10;
      send(0, 8'h99, 1'b1, 1'b1);
      repeat (3) @(negedge CLK);
      #2; req_data = 16'h2211; req_valid = 2'b11;
      #1; RST = 1'b1;
      #1;
      chk("amid_rst_tx_data", tx_data, 0);
      chk("amid_rst_par_en", tx_par_en, 0);
      chk("amid_rst_par_typ", tx_par_typ, 0);
      chk("amid_rst_arb_busy", arb_busy, 0);
      chk("amid_rst_req_ready", req_ready, 0);
      chk("amid_rst_valid_err", {tx_valid, start_err, grant_id}, 0);
      repeat (2) @(posedge CLK);
      #1; RST = 1'b0;
      errk = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         if (req_ready != '0) begin errk = int'(req_ready); break; end
      end
      chk("post_reset_first", errk, 1);
      @(posedge CLK); #1; req_valid = 2'b00;
      wait_idle();

      // Statistics window: 3 frames plus 1 timeout after a fresh reset.
      @(posedge CLK); #1; RST = 1'b1;
      @(posedge CLK); #1; RST = 1'b0;
      tx_dly = 1; tx_len = 2;
      send(0, 8'h01, 1'b0, 1'b0); wait_idle();
      send(1, 8'h02, 1'b0, 1'b0); wait_idle();
      send(0, 8'h03, 1'b0, 1'b0); wait_idle();
      tx_silent = 1'b1;
      send(1, 8'h04, 1'b0, 1'b0); wait_idle();
      tx_silent = 1'b0;
`ifdef UART_TX_ARB_STATS_EN
      chk("stats_frame_cnt", frame_cnt, 3);
      chk("stats_err_cnt", err_cnt, 1);
`endif

      repeat (3) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
